// File: rtl/seq_bubble_sorter.sv
// Sequential odd-even transposition sorter: one compare-exchange phase per clock,
// runtime ascending/descending order, early exit once two phases in a row make no swap.
module seq_bubble_sorter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N     = 5,
  localparam int unsigned PW   = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               desc,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               busy,
  output logic               done,
  output logic [N*WIDTH-1:0] out_data,
  output logic [PW-1:0]      phases
);

  typedef enum logic {StIdle, StSort} state_e;

  state_e             state_q, state_d;
  logic [N*WIDTH-1:0] data_q, data_d;
  logic               mode_q, mode_d;
  logic [PW-1:0]      cnt_q, cnt_d;
  logic               prev_swap_q, prev_swap_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PW-1:0]      phases_q, phases_d;

  logic [N*WIDTH-1:0] phase_data;
  logic               cur_swap;
  logic [WIDTH-1:0]   elem_a, elem_b;
  logic               last_phase;

  // Pairs start at index 0 on even phases and index 1 on odd phases.
  always_comb begin
    phase_data = data_q;
    cur_swap   = 1'b0;
    elem_a     = '0;
    elem_b     = '0;
    for (int i = 0; i < int'(N) - 1; i++) begin
      if (i[0] == cnt_q[0]) begin
        elem_a = data_q[i*WIDTH +: WIDTH];
        elem_b = data_q[(i+1)*WIDTH +: WIDTH];
        if (mode_q ? (elem_a < elem_b) : (elem_a > elem_b)) begin
          phase_data[i*WIDTH +: WIDTH]     = elem_b;
          phase_data[(i+1)*WIDTH +: WIDTH] = elem_a;
          cur_swap                         = 1'b1;
        end
      end
    end
  end

  assign last_phase = (cnt_q == PW'(N - 1)) ||
                      (!cur_swap && !prev_swap_q && (cnt_q != '0));

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    prev_swap_d = prev_swap_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    phases_d    = phases_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          data_d      = in_data;
          mode_d      = desc;
          cnt_d       = '0;
          prev_swap_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = StSort;
        end
      end
      StSort: begin
        data_d      = phase_data;
        cnt_d       = cnt_q + PW'(1);
        prev_swap_d = cur_swap;
        if (last_phase) begin
          state_d  = StIdle;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          phases_d = cnt_q + PW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      data_q      <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      prev_swap_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      phases_q    <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      prev_swap_q <= prev_swap_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      phases_q    <= phases_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_data = data_q;
  assign phases   = phases_q;

endmodule

// File: tb/tb_seq_bubble_sorter.sv
// Scoreboard bench for seq_bubble_sorter (N=5, WIDTH=4): stimulus pushes expected
// result, phase count and done cycle; a negedge monitor pops and checks on every done.
module tb_seq_bubble_sorter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned N     = 5;
  localparam int unsigned PW    = $clog2(N + 1);

  logic               clk;
  logic               rst;
  logic               start;
  logic               desc;
  logic [N*WIDTH-1:0] in_data;
  logic               busy;
  logic               done;
  logic [N*WIDTH-1:0] out_data;
  logic [PW-1:0]      phases;

  seq_bubble_sorter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .desc     (desc),
    .in_data  (in_data),
    .busy     (busy),
    .done     (done),
    .out_data (out_data),
    .phases   (phases)
  );

  typedef struct {
    logic [N*WIDTH-1:0] data;
    int                 ph;
    int                 done_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  logic prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [N*WIDTH-1:0] pk(input int e0, input int e1, input int e2,
                                            input int e3, input int e4);
    return {e4[3:0], e3[3:0], e2[3:0], e1[3:0], e0[3:0]};
  endfunction

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (prev_done) check("done_one_cycle", 32'(done), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("phases", 32'(phases), 32'(e.ph));
          check("done_latency", 32'(cyc), 32'(e.done_cyc));
          check("busy_cycles", 32'(busy_cnt), 32'(e.ph));
        end
        busy_cnt = 0;
      end
      prev_done = done;
    end
  end

  // Called at a negedge with the DUT idle; start is taken at the next posedge.
  task automatic issue(input logic [N*WIDTH-1:0] din, input logic d,
                       input logic [N*WIDTH-1:0] exp_data, input int ph);
    exp_t e;
    e.data     = exp_data;
    e.ph       = ph;
    e.done_cyc = cyc + 1 + ph;
    sb.push_back(e);
    start   = 1'b1;
    in_data = din;
    desc    = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    desc    = 1'b0;
    in_data = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", 32'(out_data), 32'd0);
    check("rst_phases", 32'(phases), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    issue(pk(3, 1, 4, 1, 5), 1'b0, pk(1, 1, 3, 4, 5), 4);
    wait_drain();
    issue(pk(9, 7, 5, 3, 1), 1'b0, pk(1, 3, 5, 7, 9), 5);
    wait_drain();
    issue(pk(0, 2, 4, 6, 8), 1'b0, pk(0, 2, 4, 6, 8), 2);
    wait_drain();

    // Back-to-back: new start issued in the cycle done is high.
    issue(pk(3, 1, 4, 1, 5), 1'b1, pk(5, 4, 3, 1, 1), 5);
    wait_done();
    issue(pk(15, 0, 15, 0, 7), 1'b0, pk(0, 0, 7, 15, 15), 5);
    wait_drain();

    // Start while busy must be ignored.
    issue(pk(9, 7, 5, 3, 1), 1'b0, pk(1, 3, 5, 7, 9), 5);
    @(negedge clk);
    start   = 1'b1;
    desc    = 1'b1;
    in_data = pk(1, 1, 1, 1, 1);
    @(negedge clk);
    start = 1'b0;
    desc  = 1'b0;
    wait_drain();

    // Asynchronous reset between clock edges in the middle of a sort.
    issue(pk(9, 7, 5, 3, 1), 1'b0, pk(1, 3, 5, 7, 9), 5);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_out", 32'(out_data), 32'd0);
    check("mid_rst_phases", 32'(phases), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_hold_done", 32'(done), 32'd0);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_idle_busy", 32'(busy), 32'd0);
    issue(pk(3, 1, 4, 1, 5), 1'b0, pk(1, 1, 3, 4, 5), 4);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
